approx_add_pipe: RTL and testbench

Parametrised, pipelined approximate adder with a runtime exact/approximate mode, a valid/ready stream interface and a built-in error monitor. It succeeds the fixed 8-bit combinational approximate adders in the library. The low `APPROX_BITS` bits are OR-approximated, with no carry out of that region. The block sits in datapath accelerators where per-transaction accuracy must be switchable and measured on-line.

---
 rtl/approx_add_pkg.sv | 33 +++
 rtl/approx_add_stage.sv | 93 +++++++++
 rtl/approx_add_pipe.sv | 151 +++++++++++++++
 tb/tb_approx_add_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_add_pkg.sv
// approx_add_pkg
//   Shared types and helpers for the pipelined approximate adder.
//   mode_e      : per-beat arithmetic mode (exact / approximate).
//   chunk_w()   : bits added per pipeline stage.
//   params_ok() : parameter legality, evaluated at elaboration by the top level.
package approx_add_pkg;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_e;

    // Guarded so an illegal STAGES of 0 reaches the $fatal check instead of
    // dividing by zero first.
    function automatic int unsigned chunk_w(input int unsigned width,
                                            input int unsigned stages);
        return (stages == 0) ? 1 : width / stages;
    endfunction

    function automatic bit params_ok(input int unsigned width,
                                     input int unsigned approx_bits,
                                     input int unsigned stages,
                                     input int unsigned cnt_w);
        if (width < 2)             return 1'b0;
        if (approx_bits > width)   return 1'b0;
        if (stages < 1)            return 1'b0;
        if (stages > width)        return 1'b0;
        if ((width % stages) != 0) return 1'b0;
        if (cnt_w < 1)             return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/approx_add_stage.sv
// approx_add_stage
//   One pipeline stage: adds chunk IDX (CW bits) of the operands using the
//   carry registered by the previous stage, then registers everything.
//   Bits flagged in approx_mask are OR-approximated, kill the carry and
//   record a&b as error; the chunk straddling the approximate boundary is
//   therefore split bit by bit.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   en              global pipeline enable (low = hold every register)
//   in_*            beat state from the previous stage
//   approx_mask     per-bit approximate-region flags for this chunk
//   out_*           registered beat state towards the next stage
module approx_add_stage
    import approx_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = 4,
    parameter int unsigned IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  mode_e            in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_err,
    input  logic             in_carry,
    input  logic [CW-1:0]    approx_mask,
    output logic             out_valid,
    output mode_e            out_mode,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_sum,
    output logic [WIDTH-1:0] out_err,
    output logic             out_carry
);

    logic [CW-1:0]    chunk_a;
    logic [CW-1:0]    chunk_b;
    logic [CW-1:0]    chunk_s;
    logic [CW-1:0]    chunk_e;
    logic [CW:0]      carry;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] err_d;

    always_comb begin
        chunk_a  = in_a[IDX*CW +: CW];
        chunk_b  = in_b[IDX*CW +: CW];
        chunk_s  = '0;
        chunk_e  = '0;
        carry    = '0;
        carry[0] = in_carry;
        for (int j = 0; j < CW; j++) begin
            if (approx_mask[j]) begin
                // Approximate bit: no carry leaves it, the lost a&b is the error.
                chunk_s[j]   = chunk_a[j] | chunk_b[j];
                chunk_e[j]   = chunk_a[j] & chunk_b[j];
                carry[j+1]   = 1'b0;
            end else begin
                chunk_s[j]   = chunk_a[j] ^ chunk_b[j] ^ carry[j];
                carry[j+1]   = (chunk_a[j] & chunk_b[j]) |
                               (carry[j] & (chunk_a[j] ^ chunk_b[j]));
            end
        end
        sum_d                 = in_sum;
        sum_d[IDX*CW +: CW]   = chunk_s;
        err_d                 = in_err;
        err_d[IDX*CW +: CW]   = chunk_e;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mode  <= MODE_EXACT;
            out_a     <= '0;
            out_b     <= '0;
            out_sum   <= '0;
            out_err   <= '0;
            out_carry <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
            out_mode  <= in_mode;
            out_a     <= in_a;
            out_b     <= in_b;
            out_sum   <= sum_d;
            out_err   <= err_d;
            out_carry <= carry[CW];
        end
    end

endmodule

// File: rtl/approx_add_pipe.sv
// approx_add_pipe
//   Pipelined adder with a per-beat exact/approximate mode. In approximate
//   mode the low APPROX_BITS bits are a|b with no carry out of that region.
//   STAGES chunk adders are chained with registered carries; a single global
//   enable stalls the whole pipe when the output is not accepted. An on-line
//   monitor counts erroneous results and tracks the largest error delivered.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          operand beat handshake
//   in_a, in_b, in_mode        operands and mode (0 exact, 1 approximate)
//   out_valid/out_ready        result handshake
//   out_sum, out_err, out_mode result, exact minus delivered sum, mode
//   clr_stats                  synchronous clear of err_cnt / err_max
//   err_cnt, err_max           saturating error count, maximum error
module approx_add_pipe
    import approx_add_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_BITS = 1,
    parameter int unsigned STAGES      = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic [WIDTH-1:0] out_err,
    output logic             out_mode,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0] err_max
);

    localparam int unsigned CHUNK_W = chunk_w(WIDTH, STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (!params_ok(WIDTH, APPROX_BITS, STAGES, CNT_W)) begin : g_bad_params
        $fatal(1, "approx_add_pipe: illegal WIDTH/APPROX_BITS/STAGES/CNT_W");
    end

    // Approximate-region flags of chunk idx, valid for approximate beats only.
    function automatic logic [CHUNK_W-1:0] region_mask(input int unsigned idx);
        logic [CHUNK_W-1:0] m;
        m = '0;
        for (int unsigned j = 0; j < CHUNK_W; j++) begin
            m[j] = ((idx * CHUNK_W) + j) < APPROX_BITS;
        end
        return m;
    endfunction

    // Index i is the input of stage i; index STAGES is the output register.
    logic             pipe_valid [STAGES+1];
    mode_e            pipe_mode  [STAGES+1];
    logic [WIDTH-1:0] pipe_a     [STAGES+1];
    logic [WIDTH-1:0] pipe_b     [STAGES+1];
    logic [WIDTH-1:0] pipe_sum   [STAGES+1];
    logic [WIDTH-1:0] pipe_err   [STAGES+1];
    logic             pipe_carry [STAGES+1];
    logic [CHUNK_W-1:0] stage_mask [STAGES];

    logic stall;
    logic en;
    logic handshake;

    assign pipe_valid[0] = in_valid;
    assign pipe_mode[0]  = mode_e'(in_mode);
    assign pipe_a[0]     = in_a;
    assign pipe_b[0]     = in_b;
    assign pipe_sum[0]   = '0;
    assign pipe_err[0]   = '0;
    assign pipe_carry[0] = 1'b0;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam logic [CHUNK_W-1:0] REGION = region_mask(i);

        assign stage_mask[i] = (pipe_mode[i] == MODE_APPROX) ? REGION : '0;

        approx_add_stage #(
            .WIDTH (WIDTH),
            .CW    (CHUNK_W),
            .IDX   (i)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (en),
            .in_valid    (pipe_valid[i]),
            .in_mode     (pipe_mode[i]),
            .in_a        (pipe_a[i]),
            .in_b        (pipe_b[i]),
            .in_sum      (pipe_sum[i]),
            .in_err      (pipe_err[i]),
            .in_carry    (pipe_carry[i]),
            .approx_mask (stage_mask[i]),
            .out_valid   (pipe_valid[i+1]),
            .out_mode    (pipe_mode[i+1]),
            .out_a       (pipe_a[i+1]),
            .out_b       (pipe_b[i+1]),
            .out_sum     (pipe_sum[i+1]),
            .out_err     (pipe_err[i+1]),
            .out_carry   (pipe_carry[i+1])
        );
    end

    // Operands are fully consumed once they leave the last stage.
    logic unused_tail;
    assign unused_tail = ^{pipe_a[STAGES], pipe_b[STAGES]};

    // Single global enable: bubbles hold too, so a stall freezes everything.
    assign out_valid = pipe_valid[STAGES];
    assign stall     = out_valid & ~out_ready;
    assign en        = ~stall;
    assign in_ready  = ~stall;
    assign handshake = out_valid & out_ready;

    // Results are forced to zero between valid beats.
    always_comb begin
        out_sum  = '0;
        out_err  = '0;
        out_mode = 1'b0;
        if (out_valid) begin
            out_sum  = {pipe_carry[STAGES], pipe_sum[STAGES]};
            out_err  = pipe_err[STAGES];
            out_mode = (pipe_mode[STAGES] == MODE_APPROX);
        end
    end

    // Clear has priority, dropping the contribution of a coincident beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            err_max <= '0;
        end else if (clr_stats) begin
            err_cnt <= '0;
            err_max <= '0;
        end else if (handshake) begin
            if ((out_err != '0) && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (out_err > err_max) begin
                err_max <= out_err;
            end
        end
    end

endmodule

// File: tb/tb_approx_add_pipe.sv
// tb_approx_add_pipe
//   Directed vector table plus hand-written sequences for the default
//   configuration, a saturation/clear sequence for CNT_W=4, K=3, and a
//   parallel operand sweep over K in {0,8} and STAGES in {1,4,8}.
module tb_approx_add_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   pcnt  = 0;

    always @(posedge clk) pcnt <= pcnt + 1;

    // Default instance: W=8, K=1, S=2
    logic       d_in_valid, d_in_ready, d_in_mode, d_out_valid, d_out_ready, d_out_mode, d_clr;
    logic [7:0] d_in_a, d_in_b, d_out_err, d_err_max;
    logic [8:0] d_out_sum;
    logic [15:0] d_err_cnt;

    approx_add_pipe #(.WIDTH(8), .APPROX_BITS(1), .STAGES(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_a(d_in_a), .in_b(d_in_b), .in_mode(d_in_mode), .out_valid(d_out_valid),
        .out_ready(d_out_ready), .out_sum(d_out_sum), .out_err(d_out_err),
        .out_mode(d_out_mode), .clr_stats(d_clr), .err_cnt(d_err_cnt), .err_max(d_err_max)
    );

    // Saturation instance: W=8, K=3, S=2, CNT_W=4
    logic       s_in_valid, s_in_ready, s_in_mode, s_out_valid, s_out_ready, s_out_mode, s_clr;
    logic [7:0] s_in_a, s_in_b, s_out_err, s_err_max;
    logic [8:0] s_out_sum;
    logic [3:0] s_err_cnt;

    approx_add_pipe #(.WIDTH(8), .APPROX_BITS(3), .STAGES(2), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_mode(s_in_mode), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_sum(s_out_sum), .out_err(s_out_err),
        .out_mode(s_out_mode), .clr_stats(s_clr), .err_cnt(s_err_cnt), .err_max(s_err_max)
    );

    // Sweep instances
    function automatic int sw_k(input int g);
        return (g < 3) ? 0 : 8;
    endfunction
    function automatic int sw_s(input int g);
        return ((g % 3) == 0) ? 1 : (((g % 3) == 1) ? 4 : 8);
    endfunction

    logic       w_valid, w_mode;
    logic [7:0] w_a, w_b;
    logic       w_in_ready  [6];
    logic       w_out_valid [6];
    logic       w_out_mode  [6];
    logic [8:0] w_out_sum   [6];
    logic [7:0] w_out_err   [6];
    logic [15:0] w_unused_cnt [6];
    logic [7:0] w_unused_max [6];
    logic       w_one;
    logic       w_zero;

    assign w_one  = 1'b1;
    assign w_zero = 1'b0;

    for (genvar g = 0; g < 6; g++) begin : g_sw
        approx_add_pipe #(.WIDTH(8), .APPROX_BITS(sw_k(g)), .STAGES(sw_s(g)), .CNT_W(16)) u_sw (
            .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w_in_ready[g]),
            .in_a(w_a), .in_b(w_b), .in_mode(w_mode), .out_valid(w_out_valid[g]),
            .out_ready(w_one), .out_sum(w_out_sum[g]), .out_err(w_out_err[g]),
            .out_mode(w_out_mode[g]), .clr_stats(w_zero), .err_cnt(w_unused_cnt[g]),
            .err_max(w_unused_max[g])
        );
    end

    // Reference: high part added with carry-in 0, low K bits ORed.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic mode,
                                  input int k, output logic [8:0] s, output logic [7:0] e);
        logic [7:0] m;
        m = (k >= 8) ? 8'hFF : 8'((1 << k) - 1);
        if (!mode) m = 8'h00;
        s = ({1'b0, a & ~m} + {1'b0, b & ~m}) | {1'b0, (a | b) & m};
        e = a & b & m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One isolated beat on the default instance, checking latency and result.
    task automatic d_single(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic mode, input logic [8:0] es, input logic [7:0] ee);
        int lat;
        @(negedge clk);
        d_in_valid  = 1'b1;
        d_in_a      = a;
        d_in_b      = b;
        d_in_mode   = mode;
        d_out_ready = 1'b1;
        @(posedge clk);
        #1 d_in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!d_out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 2);
        check({tag, " sum"}, d_out_sum, es);
        check({tag, " err"}, d_out_err, ee);
        check({tag, " mode"}, d_out_mode, mode);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       mode;
        logic [8:0] sum;
        logic [7:0] err;
    } vec_t;

    vec_t vt [9];
    vec_t exp_q [$];

    initial begin
        rst_n = 1'b0;
        d_in_valid = 0; d_in_a = 0; d_in_b = 0; d_in_mode = 0; d_out_ready = 1; d_clr = 0;
        s_in_valid = 0; s_in_a = 0; s_in_b = 0; s_in_mode = 0; s_out_ready = 1; s_clr = 0;
        w_valid = 0; w_a = 0; w_b = 0; w_mode = 0;

        // Reset state
        #12;
        check("reset out_valid", d_out_valid, 0);
        check("reset out_sum", d_out_sum, 0);
        check("reset err_cnt", d_err_cnt, 0);
        check("reset err_max", d_err_max, 0);
        check("reset in_ready", d_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, K=1
        vt[0] = '{8'h03, 8'h01, 1'b1, 9'h003, 8'h01};
        vt[1] = '{8'h03, 8'h01, 1'b0, 9'h004, 8'h00};
        vt[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FD, 8'h01};
        vt[3] = '{8'hFF, 8'hFF, 1'b0, 9'h1FE, 8'h00};
        vt[4] = '{8'h10, 8'h20, 1'b0, 9'h030, 8'h00};
        vt[5] = '{8'h80, 8'h80, 1'b1, 9'h100, 8'h00};
        vt[6] = '{8'h55, 8'hAA, 1'b1, 9'h0FF, 8'h00};
        vt[7] = '{8'h01, 8'h01, 1'b1, 9'h001, 8'h01};
        vt[8] = '{8'h7F, 8'h01, 1'b0, 9'h080, 8'h00};
        for (int i = 0; i < 9; i++) begin
            d_single($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].mode, vt[i].sum, vt[i].err);
        end
        @(negedge clk);
        check("table err_cnt", d_err_cnt, 3);
        check("table err_max", d_err_max, 1);

        // Random back-to-back stream with pseudo-random backpressure
        begin
            int   sent = 0;
            int   got  = 0;
            int   cyc  = 0;
            logic acc;
            vec_t v;
            vec_t r;
            while (got < 16 && cyc < 400) begin
                @(negedge clk);
                cyc++;
                d_out_ready = 1'($urandom_range(0, 1));
                if (!d_in_valid && sent < 16) begin
                    d_in_valid = 1'b1;
                    d_in_a     = 8'($urandom);
                    d_in_b     = 8'($urandom);
                    d_in_mode  = 1'($urandom_range(0, 1));
                end
                #1;
                check("stream in_ready", d_in_ready, !(d_out_valid && !d_out_ready));
                if (d_out_valid && d_out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("stream unexpected beat", 1, 0);
                    end else begin
                        r = exp_q.pop_front();
                        check("stream sum", d_out_sum, r.sum);
                        check("stream err", d_out_err, r.err);
                        check("stream mode", d_out_mode, r.mode);
                    end
                    got++;
                end
                acc = d_in_valid && d_in_ready;
                if (acc) begin
                    v.a = d_in_a; v.b = d_in_b; v.mode = d_in_mode;
                    model(v.a, v.b, v.mode, 1, v.sum, v.err);
                    exp_q.push_back(v);
                    sent++;
                end
                @(posedge clk);
                #1 if (acc) d_in_valid = 1'b0;
            end
            check("stream beats delivered", got, 16);
        end

        // Reset with two beats in flight and the output stalled
        @(negedge clk);
        d_out_ready = 1'b0;
        d_in_valid  = 1'b1; d_in_a = 8'h11; d_in_b = 8'h22; d_in_mode = 1'b0;
        @(posedge clk);
        #1 d_in_a = 8'h33; d_in_b = 8'h44;
        @(posedge clk);
        #1 d_in_valid = 1'b0;
        @(negedge clk);
        check("stall out_valid", d_out_valid, 1);
        check("stall out_sum", d_out_sum, 9'h033);
        check("stall in_ready", d_in_ready, 0);
        @(negedge clk);
        check("stall hold sum", d_out_sum, 9'h033);
        #2 rst_n = 1'b0;
        #1;
        check("midreset out_valid", d_out_valid, 0);
        check("midreset out_sum", d_out_sum, 0);
        check("midreset out_err", d_out_err, 0);
        check("midreset out_mode", d_out_mode, 0);
        check("midreset err_cnt", d_err_cnt, 0);
        check("midreset err_max", d_err_max, 0);
        @(negedge clk);
        rst_n = 1'b1;
        d_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("postreset no stale beat", d_out_valid, 0);
        d_single("postreset", 8'h10, 8'h20, 1'b0, 9'h030, 8'h00);

        // Saturation, CNT_W=4, K=3
        @(negedge clk);
        s_in_valid = 1'b1; s_in_a = 8'h07; s_in_b = 8'h07; s_in_mode = 1'b1; s_out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("sat first valid", s_out_valid, 1);
                check("sat first sum", s_out_sum, 9'h007);
                check("sat first err", s_out_err, 8'h07);
            end
            if (i == 5) check("sat partial count", s_err_cnt, 4);
        end
        s_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("sat err_cnt", s_err_cnt, 15);
        check("sat err_max", s_err_max, 7);
        s_in_valid = 1'b1;
        @(posedge clk);
        #1 s_in_valid = 1'b0;
        begin
            int n = 0;
            @(negedge clk);
            while (!s_out_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("clr beat arrives", s_out_valid, 1);
        end
        s_clr = 1'b1;
        @(posedge clk);
        #1 s_clr = 1'b0;
        @(negedge clk);
        check("clr err_cnt", s_err_cnt, 0);
        check("clr err_max", s_err_max, 0);
        check("clr beat transferred", s_out_valid, 0);

        // Operand sweep: all a, b in steps of 5, both modes
        begin
            logic [7:0] ha [16];
            logic [7:0] hb [16];
            logic       hm [16];
            logic       hv [16];
            logic [8:0] es;
            logic [7:0] ee;
            int         nb;
            int         idx;
            int         shown;
            nb    = 256 * 52 * 2;
            shown = 0;
            for (int i = 0; i < 16; i++) begin
                hv[i] = 0; ha[i] = 0; hb[i] = 0; hm[i] = 0;
            end
            @(negedge clk);
            for (int n = 0; n < nb + 12; n++) begin
                for (int g = 0; g < 6; g++) begin
                    idx = (pcnt - sw_s(g) + 1) & 15;
                    es  = '0;
                    ee  = '0;
                    if (hv[idx]) model(ha[idx], hb[idx], hm[idx], sw_k(g), es, ee);
                    tests++;
                    if (w_out_valid[g] !== hv[idx] || w_in_ready[g] !== 1'b1 ||
                        (hv[idx] && (w_out_sum[g] !== es || w_out_err[g] !== ee ||
                                     w_out_mode[g] !== hm[idx]))) begin
                        fails++;
                        if (shown < 20) begin
                            shown++;
                            $display("FAIL sweep k=%0d s=%0d a=%h b=%h m=%0d: valid %b sum %h err %h, expected valid %b sum %h err %h",
                                     sw_k(g), sw_s(g), ha[idx], hb[idx], hm[idx], w_out_valid[g],
                                     w_out_sum[g], w_out_err[g], hv[idx], es, ee);
                        end
                    end
                end
                idx = (pcnt + 1) & 15;
                if (n < nb) begin
                    w_valid = 1'b1;
                    w_a     = 8'(n / 104);
                    w_b     = 8'(((n / 2) % 52) * 5);
                    w_mode  = 1'(n & 1);
                end else begin
                    w_valid = 1'b0;
                end
                hv[idx] = w_valid; ha[idx] = w_a; hb[idx] = w_b; hm[idx] = w_mode;
                @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
